dot_update_queue: RTL and testbench

- Processor-side bridge that buffers dot-position writes and replays them to the VGA controller's dot register port (dotWren/is_Yloc/dotID/dotLoc).
- Replay happens only in the blanking gap that starts at screenEnd, so no dot moves mid-frame.
- Each replayed write is held long enough for the controller's 25 MHz sampling domain to capture it.
- Sits between the CPU memory-mapped write path and the VGA controller.

---
 rtl/dot_pkg.sv | 17 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/dot_update_queue.sv | 114 +++++++++++
 tb/tb_dot_update_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// dot_pkg: shared widths, FIFO entry layout and FSM states for dot_update_queue
// Contents: NUM_DOTS, ID_W, LOC_W, dot_entry_t {is_y, id, loc}, state_t, make_entry()
package dot_pkg;
  localparam int NUM_DOTS = 8;
  localparam int ID_W = $clog2(NUM_DOTS);
  localparam int LOC_W = 10;
  typedef struct packed {
    logic is_y;
    logic [ID_W-1:0] id;
    logic [LOC_W-1:0] loc;
  } dot_entry_t;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  // Y coordinates only carry 9 significant bits; bit 9 is forced low for them
  function automatic dot_entry_t make_entry(input logic is_y, input logic [ID_W-1:0] id, input logic [LOC_W-1:0] loc);
    return '{is_y: is_y, id: id, loc: is_y ? {1'b0, loc[8:0]} : loc};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full and a look-ahead view of the entry after the head
// Ports: clk, reset (sync, active-low); push/din write; pop removes head; head = oldest entry;
//   nxt = entry that becomes head after a pop (din when only one entry is stored); count, full, empty.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic full_q;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign head = mem_q[rd_q];
  assign nxt = count_q > CW'(1) ? mem_q[rd_q + AW'(1)] : din;
  assign count = count_q;
  assign full = full_q;
  assign empty = count_q == '0;
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
    end else begin
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      count_q <= count_d;
      full_q <= count_d == CW'(DEPTH);
    end
  end
endmodule

// File: rtl/dot_update_queue.sv
// dot_update_queue: buffers CPU dot-position writes and replays them to the VGA dot port in the frame gap
// Ports: clk, reset (sync, active-low); wr_en/wr_is_y/wr_id/wr_loc CPU write; screenEnd frame-gap pulse;
//   dotWren/is_Yloc/dotID/dotLoc replay port (registered); full, frame_done, overflow, bad_id status.
// NUM_DOTS lives in dot_pkg because the FIFO entry layout depends on it.
module dot_update_queue
  import dot_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_PER_FRAME = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_is_y,
  input  logic [31:0] wr_id,
  input  logic [31:0] wr_loc,
  input  logic        screenEnd,
  output logic        dotWren,
  output logic        is_Yloc,
  output logic [31:0] dotID,
  output logic [31:0] dotLoc,
  output logic        full,
  output logic        frame_done,
  output logic        overflow,
  output logic        bad_id
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int FW = $clog2(MAX_PER_FRAME + 1);
  state_t state_q;
  logic [HW-1:0] hold_q;
  logic [FW-1:0] frame_q;
  logic dot_wren_q, is_y_q, frame_done_q, overflow_q, bad_id_q;
  logic [31:0] dot_id_q, dot_loc_q;
  dot_entry_t wr_ent, head, nxt;
  logic [CW-1:0] count;
  logic empty, id_ok, last, push, more;
  logic unused_loc;
  assign unused_loc = ^wr_loc[31:LOC_W];
  assign id_ok = wr_id < 32'(NUM_DOTS);
  assign wr_ent = make_entry(wr_is_y, wr_id[ID_W-1:0], wr_loc[LOC_W-1:0]);
  // last hold cycle of the presented entry: this is when it leaves the FIFO
  assign last = state_q == DRIVE && hold_q == HW'(HOLD_CYCLES - 1);
  // a pop frees a slot in the same cycle, so a write while full still lands
  assign push = wr_en && id_ok && (!full || last);
  // a same-cycle push counts toward "still non-empty after this pop"
  assign more = (count > CW'(1) || push) && frame_q + FW'(1) < FW'(MAX_PER_FRAME);
  sync_fifo #(.W($bits(dot_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(last),
    .din(wr_ent),
    .head(head),
    .nxt(nxt),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      frame_q <= '0;
      dot_wren_q <= 1'b0;
      is_y_q <= 1'b0;
      dot_id_q <= '0;
      dot_loc_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q <= 1'b0;
      bad_id_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overflow_q <= overflow_q | (wr_en && id_ok && full && !last);
      bad_id_q <= bad_id_q | (wr_en && !id_ok);
      case (state_q)
        IDLE: begin
          if (screenEnd && empty) frame_done_q <= 1'b1;
          if (screenEnd && !empty) begin
            state_q <= DRIVE;
            hold_q <= '0;
            frame_q <= '0;
            dot_wren_q <= 1'b1;
            is_y_q <= head.is_y;
            dot_id_q <= 32'(head.id);
            dot_loc_q <= 32'(head.loc);
          end
        end
        DRIVE: begin
          hold_q <= last ? '0 : hold_q + HW'(1);
          if (last) begin
            frame_q <= frame_q + FW'(1);
            state_q <= more ? DRIVE : DONE;
            frame_done_q <= !more;
            dot_wren_q <= more;
            is_y_q <= more && nxt.is_y;
            dot_id_q <= more ? 32'(nxt.id) : '0;
            dot_loc_q <= more ? 32'(nxt.loc) : '0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dotWren = dot_wren_q;
  assign is_Yloc = is_y_q;
  assign dotID = dot_id_q;
  assign dotLoc = dot_loc_q;
  assign frame_done = frame_done_q;
  assign overflow = overflow_q;
  assign bad_id = bad_id_q;
endmodule

// File: tb/tb_dot_update_queue.sv
// tb_dot_update_queue: scoreboard bench for dot_update_queue
module tb_dot_update_queue;
  typedef struct packed {
    logic y;
    logic [31:0] id;
    logic [31:0] loc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic wr_is_y = 1'b0;
  logic [31:0] wr_id = '0;
  logic [31:0] wr_loc = '0;
  logic screenEnd = 1'b0;
  logic dotWren, is_Yloc, full, frame_done, overflow, bad_id;
  logic [31:0] dotID, dotLoc;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_pass = 0;
  int run = 0;
  int max_run = 0;
  int wren_cyc = 0;
  int fd_cnt = 0;
  int mdl_cnt = 0;
  int fd0 = 0;
  logic ovf_exp = 1'b0;
  logic bad_exp = 1'b0;

  always #5 clk = ~clk;

  dot_update_queue dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_is_y(wr_is_y),
    .wr_id(wr_id),
    .wr_loc(wr_loc),
    .screenEnd(screenEnd),
    .dotWren(dotWren),
    .is_Yloc(is_Yloc),
    .dotID(dotID),
    .dotLoc(dotLoc),
    .full(full),
    .frame_done(frame_done),
    .overflow(overflow),
    .bad_id(bad_id)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // model: accepted writes go to the scoreboard; mdl_cnt tracks DUT FIFO occupancy
  task automatic wr(input logic y, input logic [31:0] id, input logic [31:0] loc);
    exp_t e;
    wr_en = 1'b1;
    wr_is_y = y;
    wr_id = id;
    wr_loc = loc;
    if (id >= 32'd8) bad_exp = 1'b1;
    else if (mdl_cnt >= 16) ovf_exp = 1'b1;
    else begin
      mdl_cnt++;
      e.y = y;
      e.id = id;
      e.loc = loc & (y ? 32'h1ff : 32'h3ff);
      exp_q.push_back(e);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic se();
    screenEnd = 1'b1;
    tick();
    screenEnd = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int k = 0;
    while (!frame_done && k < 300) begin
      tick();
      k++;
    end
    chk(tag, frame_done, 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt = 0;
    ovf_exp = 1'b0;
    bad_exp = 1'b0;
  endtask

  // monitor: first cycle of each hold window pops the scoreboard; last cycle frees a model slot
  always @(negedge clk) begin
    if (!reset) run = 0;
    else begin
      if (dotWren) begin
        run++;
        wren_cyc++;
        if (run > max_run) max_run = run;
        if (run % 4 == 1) begin
          if (exp_q.size() == 0) chk("unexpected_replay", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("replay_is_y", is_Yloc, mon_e.y);
            chk("replay_id", dotID, mon_e.id);
            chk("replay_loc", dotLoc, mon_e.loc);
          end
        end
        if (run % 4 == 0) mdl_cnt--;
      end else run = 0;
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle frame gap
    repeat (3) tick();
    chk("rst_wren", dotWren, 0);
    chk("rst_id", dotID, 0);
    chk("rst_loc", dotLoc, 0);
    chk("rst_full", full, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_flags", {overflow, bad_id}, 0);
    reset = 1'b1;
    tick();
    se();
    chk("idle_fd", frame_done, 1);
    chk("idle_wren", dotWren, 0);
    tick();
    chk("idle_fd_end", frame_done, 0);
    chk("idle_no_wren", wren_cyc, 0);
    // single replay with exact timing
    wr(1'b0, 32'd3, 32'd100);
    tick();
    se();
    for (int i = 0; i < 4; i++) begin
      chk("single_wren", dotWren, 1);
      chk("single_id", dotID, 3);
      chk("single_loc", dotLoc, 100);
      chk("single_is_y", is_Yloc, 0);
      chk("single_fd_low", frame_done, 0);
      tick();
    end
    chk("single_wren_off", dotWren, 0);
    chk("single_fd", frame_done, 1);
    chk("single_done_id", dotID, 0);
    tick();
    chk("single_fd_end", frame_done, 0);
    se();
    chk("single_empty_fd", frame_done, 1);
    chk("single_sb_empty", exp_q.size(), 0);
    // fill past full, budget per frame, push while full with same-cycle pop
    tick();
    for (int i = 0; i < 20; i++) begin
      wr(i[0], 32'(i % 8), 32'(500 + 7 * i));
      if (i == 14) chk("full_at_15", full, 0);
      if (i == 15) chk("full_at_16", full, 1);
    end
    chk("overflow_set", overflow, ovf_exp);
    chk("overflow_one", overflow, 1);
    wren_cyc = 0;
    se();
    repeat (6) tick();
    wr(1'b1, 32'd2, 32'd777);
    wr(1'b0, 32'd5, 32'd1000);
    wait_fd("budget_fd");
    chk("budget_wren_cycles", wren_cyc, 64);
    chk("budget_left", exp_q.size(), 2);
    chk("budget_full_clear", full, 0);
    tick();
    wren_cyc = 0;
    se();
    wait_fd("rest_fd");
    chk("rest_wren_cycles", wren_cyc, 8);
    chk("rest_sb_empty", exp_q.size(), 0);
    tick();
    se();
    chk("rest_empty_fd", frame_done, 1);
    tick();
    chk("rest_no_wren", wren_cyc, 8);
    // bad ids after a fresh reset
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    chk("flags_cleared", {overflow, bad_id}, 0);
    tick();
    wr(1'b0, 32'h0100_0003, 32'd6);
    chk("bad_id_high_bits", bad_id, bad_exp);
    wr(1'b1, 32'd8, 32'd5);
    chk("bad_id_sticky", bad_id, 1);
    chk("bad_no_overflow", overflow, 0);
    wren_cyc = 0;
    se();
    chk("bad_empty_fd", frame_done, 1);
    tick();
    chk("bad_no_replay", wren_cyc, 0);
    // push during drain, mid-drain screenEnd ignored
    wren_cyc = 0;
    max_run = 0;
    fd0 = fd_cnt;
    wr(1'b0, 32'd1, 32'd11);
    wr(1'b1, 32'd6, 32'd22);
    se();
    wr(1'b0, 32'd7, 32'd33);
    tick();
    se();
    wait_fd("drain_fd");
    repeat (3) tick();
    chk("drain_wren_cycles", wren_cyc, 12);
    chk("drain_back_to_back", max_run, 12);
    chk("drain_one_fd", fd_cnt - fd0, 1);
    chk("drain_sb_empty", exp_q.size(), 0);
    // reset in the middle of a drain
    wr(1'b0, 32'd4, 32'd44);
    wr(1'b1, 32'd5, 32'd55);
    se();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("midrst_wren", dotWren, 0);
    chk("midrst_id", dotID, 0);
    chk("midrst_fd", frame_done, 0);
    reset = 1'b1;
    tick();
    wren_cyc = 0;
    se();
    chk("midrst_empty_fd", frame_done, 1);
    repeat (6) tick();
    chk("midrst_no_replay", wren_cyc, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
